// File: rtl/weight_bias_acc_seq.sv
// Mini-batch accumulator of lr*delta*activation terms for all output-layer and
// hidden-layer weights and biases, using one shared multiply path stepped by an FSM.
// Accumulator slot order (also the processing order): output biases, hidden biases,
// output weights (o*N_HL_P+h), hidden weights (h*N_IN+i).
module weight_bias_acc_seq #(
    parameter int N_IN   = 2,
    parameter int N_HL_P = 3,
    parameter int N_OUT  = 2,
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int CW     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_clr,
    input  logic [CW-1:0]                   i_batch,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [WIDTH-1:0]                i_lr,
    input  logic [N_IN*WIDTH-1:0]           i_k,
    input  logic [N_HL_P*WIDTH-1:0]         i_hd_a,
    input  logic [N_OUT*WIDTH-1:0]          i_dlto,
    input  logic [N_HL_P*WIDTH-1:0]         i_dlth,
    output logic                            o_valid,
    input  logic                            i_ack,
    output logic [CW-1:0]                   o_cnt,
    output logic [N_OUT*WIDTH-1:0]          o_bias_o,
    output logic [N_HL_P*WIDTH-1:0]         o_bias_hd,
    output logic [N_OUT*N_HL_P*WIDTH-1:0]   o_wght_o,
    output logic [N_HL_P*N_IN*WIDTH-1:0]    o_wght_hd
);

    localparam int K   = N_OUT*(N_HL_P+1) + N_HL_P*(N_IN+1);
    localparam int NWO = N_OUT*N_HL_P;
    localparam int NWH = N_HL_P*N_IN;
    localparam int BH  = N_OUT;
    localparam int BWO = N_OUT + N_HL_P;
    localparam int BWH = BWO + NWO;
    localparam int IW  = (K > 1) ? $clog2(K) : 1;
    localparam int WW  = 2*WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           batch_q;
    logic                    valid_q;
    logic signed [WIDTH-1:0] lr_q;
    logic signed [WIDTH-1:0] k_q    [N_IN];
    logic signed [WIDTH-1:0] hdA_q  [N_HL_P];
    logic signed [WIDTH-1:0] dltO_q [N_OUT];
    logic signed [WIDTH-1:0] dltH_q [N_HL_P];
    logic signed [WIDTH-1:0] acc_q  [K];

    logic signed [WIDTH-1:0] dTerm [K];
    logic signed [WIDTH-1:0] aTerm [K];
    logic [K-1:0]            wTerm;

    logic signed [WIDTH-1:0] dSel;
    logic signed [WIDTH-1:0] aSel;
    logic                    isWeight;
    logic signed [WIDTH-1:0] accSel;
    logic signed [WW-1:0]    prodLd;
    logic signed [WW-1:0]    prodPa;
    logic signed [WIDTH-1:0] pVal;
    logic signed [WIDTH-1:0] termVal;
    logic signed [WIDTH-1:0] accSel_d;
    logic [CW-1:0]           cntNext;
    logic [CW-1:0]           batchEff;

    function automatic logic signed [WW-1:0] sext(input logic signed [WIDTH-1:0] x);
        return {{WIDTH{x[WIDTH-1]}}, x};
    endfunction

    // Clamp a double-width value into the signed WIDTH range.
    function automatic logic signed [WIDTH-1:0] satW(input logic signed [WW-1:0] x);
        if ((&x[WW-1:WIDTH-1]) || !(|x[WW-1:WIDTH-1]))
            return x[WIDTH-1:0];
        else if (x[WW-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // Static wiring of each term slot to its delta, activation and bias/weight kind.
    for (genvar t = 0; t < K; t++) begin : gTerm
        if (t < BH) begin : gBiasO
            assign dTerm[t] = dltO_q[t];
            assign aTerm[t] = '0;
            assign wTerm[t] = 1'b0;
        end else if (t < BWO) begin : gBiasH
            assign dTerm[t] = dltH_q[t-BH];
            assign aTerm[t] = '0;
            assign wTerm[t] = 1'b0;
        end else if (t < BWH) begin : gWghtO
            assign dTerm[t] = dltO_q[(t-BWO)/N_HL_P];
            assign aTerm[t] = hdA_q[(t-BWO)%N_HL_P];
            assign wTerm[t] = 1'b1;
        end else begin : gWghtH
            assign dTerm[t] = dltH_q[(t-BWH)/N_IN];
            assign aTerm[t] = k_q[(t-BWH)%N_IN];
            assign wTerm[t] = 1'b1;
        end
    end

    // Select the operands and current accumulator for the term being processed.
    always_comb begin
        dSel     = '0;
        aSel     = '0;
        isWeight = 1'b0;
        accSel   = '0;
        for (int t = 0; t < K; t++) begin
            if (idx_q == IW'(t)) begin
                dSel     = dTerm[t];
                aSel     = aTerm[t];
                isWeight = wTerm[t];
                accSel   = acc_q[t];
            end
        end
    end

    // Shared multiply path: full-width products, arithmetic shift, then saturate.
    always_comb begin
        prodLd   = sext(lr_q) * sext(dSel);
        pVal     = satW(prodLd >>> FRAC);
        prodPa   = sext(pVal) * sext(aSel);
        termVal  = isWeight ? satW(prodPa >>> FRAC) : pVal;
        accSel_d = satW(sext(accSel) + sext(termVal));
        cntNext  = cnt_q + CW'(1);
        batchEff = (batch_q == '0) ? CW'(1) : batch_q;
    end

    // Sequencer: accept a sample, walk all K terms, then hold results until acknowledged.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            batch_q <= '0;
            valid_q <= 1'b0;
            for (int t = 0; t < K; t++) acc_q[t] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        lr_q    <= i_lr;
                        batch_q <= i_batch;
                        for (int i = 0; i < N_IN; i++)   k_q[i]    <= i_k[i*WIDTH +: WIDTH];
                        for (int h = 0; h < N_HL_P; h++) hdA_q[h]  <= i_hd_a[h*WIDTH +: WIDTH];
                        for (int o = 0; o < N_OUT; o++)  dltO_q[o] <= i_dlto[o*WIDTH +: WIDTH];
                        for (int h = 0; h < N_HL_P; h++) dltH_q[h] <= i_dlth[h*WIDTH +: WIDTH];
                        idx_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    for (int t = 0; t < K; t++) begin
                        if (idx_q == IW'(t)) acc_q[t] <= accSel_d;
                    end
                    if (idx_q == IW'(K-1)) begin
                        cnt_q <= cntNext;
                        if (cntNext >= batchEff) begin
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (i_ack) begin
                        for (int t = 0; t < K; t++) acc_q[t] <= '0;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Present the accumulators directly, packed in slot order with slot 0 in the LSBs.
    always_comb begin
        o_bias_o  = '0;
        o_bias_hd = '0;
        o_wght_o  = '0;
        o_wght_hd = '0;
        for (int o = 0; o < N_OUT; o++)  o_bias_o[o*WIDTH +: WIDTH]  = acc_q[o];
        for (int h = 0; h < N_HL_P; h++) o_bias_hd[h*WIDTH +: WIDTH] = acc_q[BH+h];
        for (int s = 0; s < NWO; s++)    o_wght_o[s*WIDTH +: WIDTH]  = acc_q[BWO+s];
        for (int s = 0; s < NWH; s++)    o_wght_hd[s*WIDTH +: WIDTH] = acc_q[BWH+s];
    end

    assign o_ready = (state_q == IDLE) && !i_clr;
    assign o_valid = valid_q;
    assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_weight_bias_acc_seq.sv
// Directed bench for weight_bias_acc_seq: a default-parameter instance driven from a
// vector table plus multi-cycle sequences, and a reparametrised instance with per-slot data.
module tb_weight_bias_acc_seq;

   localparam int N_IN = 2, N_HL_P = 3, N_OUT = 2, W = 32, FRAC = 16, CW = 8;
   localparam int K = N_OUT*(N_HL_P+1) + N_HL_P*(N_IN+1);
   localparam int K2 = 1*(4+1) + 4*(3+1);

   logic clk = 1'b0;
   logic rst, i_clr, i_valid, i_ack;
   logic [CW-1:0] i_batch;
   logic [W-1:0] i_lr;
   logic [N_IN*W-1:0] i_k;
   logic [N_HL_P*W-1:0] i_hd_a, i_dlth;
   logic [N_OUT*W-1:0] i_dlto;
   logic o_ready, o_valid;
   logic [CW-1:0] o_cnt;
   logic [N_OUT*W-1:0] o_bias_o;
   logic [N_HL_P*W-1:0] o_bias_hd;
   logic [N_OUT*N_HL_P*W-1:0] o_wght_o;
   logic [N_HL_P*N_IN*W-1:0] o_wght_hd;

   logic c2Clr, c2Valid, c2Ack, c2Ready, c2ValidO;
   logic [7:0] c2Batch, c2Cnt;
   logic [15:0] c2Lr, c2Dlto, c2BiasO;
   logic [47:0] c2K;
   logic [63:0] c2HdA, c2Dlth, c2BiasHd, c2WghtO;
   logic [191:0] c2WghtHd;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string name;
      logic [31:0] lr, d, a, expBias, expWght;
   } vec_t;
   vec_t vecs[7];

   logic [15:0] e2Bh[4];
   logic [15:0] e2Wo[4];
   logic [15:0] e2Wh[12];

   weight_bias_acc_seq #(.N_IN(N_IN), .N_HL_P(N_HL_P), .N_OUT(N_OUT), .WIDTH(W), .FRAC(FRAC), .CW(CW)) dut (
      .clk(clk), .rst(rst), .i_clr(i_clr), .i_batch(i_batch), .i_valid(i_valid), .o_ready(o_ready),
      .i_lr(i_lr), .i_k(i_k), .i_hd_a(i_hd_a), .i_dlto(i_dlto), .i_dlth(i_dlth), .o_valid(o_valid),
      .i_ack(i_ack), .o_cnt(o_cnt), .o_bias_o(o_bias_o), .o_bias_hd(o_bias_hd),
      .o_wght_o(o_wght_o), .o_wght_hd(o_wght_hd));

   weight_bias_acc_seq #(.N_IN(3), .N_HL_P(4), .N_OUT(1), .WIDTH(16), .FRAC(8), .CW(8)) dut2 (
      .clk(clk), .rst(rst), .i_clr(c2Clr), .i_batch(c2Batch), .i_valid(c2Valid), .o_ready(c2Ready),
      .i_lr(c2Lr), .i_k(c2K), .i_hd_a(c2HdA), .i_dlto(c2Dlto), .i_dlth(c2Dlth), .o_valid(c2ValidO),
      .i_ack(c2Ack), .o_cnt(c2Cnt), .o_bias_o(c2BiasO), .o_bias_hd(c2BiasHd),
      .o_wght_o(c2WghtO), .o_wght_hd(c2WghtHd));

   // Free-running clock shared by both instances.
   always #5 clk = ~clk;

   // Hard stop in case a sequence wedges somewhere unbounded.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkAllOutputs(input string tag, input logic [31:0] expBias, input logic [31:0] expWght);
      for (int o = 0; o < N_OUT; o++)
         checkOutput($sformatf("%s bias_o[%0d]", tag, o), o_bias_o[o*W +: W], expBias);
      for (int h = 0; h < N_HL_P; h++)
         checkOutput($sformatf("%s bias_hd[%0d]", tag, h), o_bias_hd[h*W +: W], expBias);
      for (int s = 0; s < N_OUT*N_HL_P; s++)
         checkOutput($sformatf("%s wght_o[%0d]", tag, s), o_wght_o[s*W +: W], expWght);
      for (int s = 0; s < N_HL_P*N_IN; s++)
         checkOutput($sformatf("%s wght_hd[%0d]", tag, s), o_wght_hd[s*W +: W], expWght);
   endtask

   // Offer one uniform sample and return #1 after the edge that accepts it.
   task automatic applyStimulus(input logic [31:0] lr, input logic [31:0] d, input logic [31:0] a,
                                input logic [CW-1:0] batch);
      int n = 0;
      i_lr = lr;
      i_k = {N_IN{a}};
      i_hd_a = {N_HL_P{a}};
      i_dlto = {N_OUT{d}};
      i_dlth = {N_HL_P{d}};
      i_batch = batch;
      i_valid = 1'b1;
      while (!o_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("accept ready", o_ready, 1);
      @(posedge clk); #1;
      i_valid = 1'b0;
      checkOutput("ready low after accept", o_ready, 0);
   endtask

   // Count edges until the sample finishes; it must take exactly K edges.
   task automatic waitDone(input string tag, input logic expValid);
      int n = 0;
      while (n < 200) begin
         @(posedge clk); #1; n++;
         if (o_valid || o_ready) break;
      end
      checkOutput({tag, " latency"}, n, K);
      checkOutput({tag, " o_valid"}, o_valid, expValid);
   endtask

   task automatic ackResult(input string tag);
      i_ack = 1'b1;
      @(posedge clk); #1;
      i_ack = 1'b0;
      checkOutput({tag, " ack o_valid"}, o_valid, 0);
      checkOutput({tag, " ack o_ready"}, o_ready, 1);
      checkOutput({tag, " ack o_cnt"}, o_cnt, 0);
      checkAllOutputs({tag, " ack"}, 32'h0, 32'h0);
   endtask

   initial begin
      int n;
      vecs[0] = '{"half_lr",   32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000};
      vecs[1] = '{"neg_delta", 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_0000, 32'hFFFF_8000};
      vecs[2] = '{"mixed",     32'h0000_4000, 32'h0003_0000, 32'hFFFE_0000, 32'h0000_C000, 32'hFFFE_8000};
      vecs[3] = '{"floor",     32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4] = '{"sat_neg",   32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      vecs[5] = '{"zero_lr",   32'h0000_0000, 32'h0001_2345, 32'h0005_4321, 32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{"wght_sat",  32'h0001_0000, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_0000, 32'h7FFF_FFFF};
      e2Bh = '{16'h0200, 16'hFF00, 16'h0080, 16'h0600};
      e2Wo = '{16'h0300, 16'h0600, 16'hFD00, 16'h0180};
      e2Wh = '{16'h0200, 16'h0080, 16'hFC00, 16'hFF00, 16'hFFC0, 16'h0200,
               16'h0080, 16'h0020, 16'hFF00, 16'h0600, 16'h0180, 16'hF400};

      rst = 1'b1; i_clr = 1'b0; i_valid = 1'b0; i_ack = 1'b0; i_batch = '0;
      i_lr = '0; i_k = '0; i_hd_a = '0; i_dlto = '0; i_dlth = '0;
      c2Clr = 1'b0; c2Valid = 1'b0; c2Ack = 1'b0; c2Batch = 8'd1;
      c2Lr = '0; c2K = '0; c2HdA = '0; c2Dlto = '0; c2Dlth = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset o_valid", o_valid, 0);
      checkOutput("reset o_cnt", o_cnt, 0);
      checkOutput("reset o_ready", o_ready, 1);
      checkAllOutputs("reset", 32'h0, 32'h0);

      // Single-sample batches from the vector table.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].lr, vecs[v].d, vecs[v].a, 8'd1);
         waitDone(vecs[v].name, 1'b1);
         checkOutput({vecs[v].name, " o_cnt"}, o_cnt, 1);
         checkAllOutputs(vecs[v].name, vecs[v].expBias, vecs[v].expWght);
         ackResult(vecs[v].name);
      end

      // Three-sample batch; ack and input changes during CALC must be ignored.
      applyStimulus(32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 8'd3);
      i_ack = 1'b1;
      i_lr = 32'h7FFF_FFFF; i_dlto = '1; i_dlth = '0; i_k = '1; i_hd_a = '1;
      waitDone("b3 s1", 1'b0);
      i_ack = 1'b0;
      checkOutput("b3 s1 o_cnt", o_cnt, 1);
      checkAllOutputs("b3 s1", 32'hFFFF_0000, 32'hFFFF_8000);
      applyStimulus(32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 8'd3);
      i_lr = 32'h1234_5678; i_dlto = '0; i_dlth = '1; i_k = '0; i_hd_a = '0;
      waitDone("b3 s2", 1'b0);
      checkOutput("b3 s2 o_cnt", o_cnt, 2);
      applyStimulus(32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 8'd3);
      waitDone("b3 s3", 1'b1);
      checkOutput("b3 s3 o_cnt", o_cnt, 3);
      checkAllOutputs("b3 s3", 32'hFFFD_0000, 32'hFFFE_8000);

      // Hold in DONE with a pending sample offered; nothing may move.
      i_valid = 1'b1; i_lr = 32'h0001_0000; i_dlto = '1; i_dlth = '1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("hold%0d o_valid", c), o_valid, 1);
         checkOutput($sformatf("hold%0d o_ready", c), o_ready, 0);
         checkOutput($sformatf("hold%0d o_cnt", c), o_cnt, 3);
         checkAllOutputs($sformatf("hold%0d", c), 32'hFFFD_0000, 32'hFFFE_8000);
      end
      i_valid = 1'b0;
      ackResult("b3");

      // Saturating accumulation over a two-sample batch.
      applyStimulus(32'h0001_0000, 32'h7FFF_FFFF, 32'h0002_0000, 8'd2);
      waitDone("sat s1", 1'b0);
      checkOutput("sat s1 o_cnt", o_cnt, 1);
      checkAllOutputs("sat s1", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      applyStimulus(32'h0001_0000, 32'h7FFF_FFFF, 32'h0002_0000, 8'd2);
      waitDone("sat s2", 1'b1);
      checkOutput("sat s2 o_cnt", o_cnt, 2);
      checkAllOutputs("sat s2", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      ackResult("sat");

      // Clear in the fifth CALC cycle together with a new sample offer.
      applyStimulus(32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 8'd1);
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("clr partial bias_o[0]", o_bias_o[31:0], 32'h0000_8000);
      i_clr = 1'b1; i_valid = 1'b1;
      #1;
      checkOutput("clr o_ready during clr", o_ready, 0);
      @(posedge clk); #1;
      checkOutput("clr o_valid", o_valid, 0);
      checkOutput("clr o_cnt", o_cnt, 0);
      checkOutput("clr o_ready held", o_ready, 0);
      checkAllOutputs("clr", 32'h0, 32'h0);
      @(posedge clk); #1;
      i_clr = 1'b0; i_valid = 1'b0;
      #1;
      checkOutput("clr idle o_ready", o_ready, 1);
      checkOutput("clr idle o_cnt", o_cnt, 0);

      // Batch size zero behaves as one.
      applyStimulus(32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 8'd0);
      waitDone("batch0", 1'b1);
      checkOutput("batch0 o_cnt", o_cnt, 1);
      checkAllOutputs("batch0", 32'h0000_8000, 32'h0000_8000);
      ackResult("batch0");

      // Reset in the middle of CALC.
      applyStimulus(32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 8'd1);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rstmid o_ready", o_ready, 1);
      checkOutput("rstmid o_valid", o_valid, 0);
      checkOutput("rstmid o_cnt", o_cnt, 0);
      checkAllOutputs("rstmid", 32'h0, 32'h0);

      // Reparametrised instance with per-slot values in Q8.8.
      c2Lr = 16'h0200;
      c2Dlto = 16'h0180;
      c2Dlth = {16'h0300, 16'h0040, 16'hFF80, 16'h0100};
      c2HdA = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
      c2K = {16'hFE00, 16'h0040, 16'h0100};
      c2Batch = 8'd1;
      c2Valid = 1'b1;
      checkOutput("p2 accept ready", c2Ready, 1);
      @(posedge clk); #1;
      c2Valid = 1'b0;
      n = 0;
      while (n < 200) begin
         @(posedge clk); #1; n++;
         if (c2ValidO || c2Ready) break;
      end
      checkOutput("p2 latency", n, K2);
      checkOutput("p2 o_valid", c2ValidO, 1);
      checkOutput("p2 o_cnt", c2Cnt, 1);
      checkOutput("p2 bias_o[0]", {16'h0, c2BiasO}, 32'h0000_0300);
      for (int h = 0; h < 4; h++)
         checkOutput($sformatf("p2 bias_hd[%0d]", h), {16'h0, c2BiasHd[h*16 +: 16]}, {16'h0, e2Bh[h]});
      for (int s = 0; s < 4; s++)
         checkOutput($sformatf("p2 wght_o[%0d]", s), {16'h0, c2WghtO[s*16 +: 16]}, {16'h0, e2Wo[s]});
      for (int s = 0; s < 12; s++)
         checkOutput($sformatf("p2 wght_hd[%0d]", s), {16'h0, c2WghtHd[s*16 +: 16]}, {16'h0, e2Wh[s]});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
